// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and helpers for the cache-to-AXI request arbiter.
package mem_arb_pkg;

   localparam int MAX_ADDR_W      = 64;
   localparam int BLOCK_WIDTH_DEF = 512;
   localparam int BLOCK_OFFSET_W  = $clog2(BLOCK_WIDTH_DEF / 8);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      RD_D = 2'd2,
      RD_I = 2'd3
   } arb_state_e;

   // Clears the byte-offset bits so the address points at the start of a block.
   function automatic logic [MAX_ADDR_W-1:0] block_align(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int off_w);
      logic [MAX_ADDR_W-1:0] res;
      res = addr;
      for (int i = 0; i < MAX_ADDR_W; i++) begin
         if (i < off_w) begin
            res[i] = 1'b0;
         end else begin
            res[i] = addr[i];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Request/transfer bundle between the caches, the arbiter and the AXI block master.
interface mem_req_arbiter_if #(
   parameter int ADDR_WIDTH = 64
);
   logic                  i_ireq;
   logic [ADDR_WIDTH-1:0] i_ireq_addr;
   logic                  i_ireq_cancel;
   logic                  i_dreq;
   logic                  i_dreq_dirty;
   logic [ADDR_WIDTH-1:0] i_dreq_addr;
   logic [ADDR_WIDTH-1:0] i_dwb_addr;
   logic                  i_axi_done;
   logic [ADDR_WIDTH-1:0] o_axi_addr;
   logic                  o_axi_read_start;
   logic                  o_axi_write_start;
   logic                  o_ifill_we;
   logic                  o_dfill_we;
   logic                  o_busy;
   logic                  o_timeout;

   modport slave (
      input  i_ireq, i_ireq_addr, i_ireq_cancel, i_dreq, i_dreq_dirty,
             i_dreq_addr, i_dwb_addr, i_axi_done,
      output o_axi_addr, o_axi_read_start, o_axi_write_start, o_ifill_we,
             o_dfill_we, o_busy, o_timeout
   );

   modport master (
      output i_ireq, i_ireq_addr, i_ireq_cancel, i_dreq, i_dreq_dirty,
             i_dreq_addr, i_dwb_addr, i_axi_done,
      input  o_axi_addr, o_axi_read_start, o_axi_write_start, o_ifill_we,
             o_dfill_we, o_busy, o_timeout
   );
endinterface

// File: rtl/mem_req_arbiter_watchdog.sv
// Saturating busy-cycle counter that raises a sticky flag when a transfer hangs.
module axi_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic timeout
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_r;
   logic             timeout_r;

   // Count busy cycles, flag once the limit is reached; flag only clears on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= '0;
         timeout_r <= 1'b0;
      end else begin
         if (clear) begin
            cnt_r <= '0;
         end else if (count_en && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
         if (!clear && count_en && (cnt_r == (LIMIT - CNT_W'(1)))) begin
            timeout_r <= 1'b1;
         end else begin
            timeout_r <= timeout_r;
         end
      end
   end

   assign timeout = timeout_r;
endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one AXI block-transfer port between icache refills and dcache write-back/refill.
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 64,
   parameter int BLOCK_WIDTH    = 512,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic          i_clk,
   input  logic          i_arst,
   mem_req_arbiter_if.slave bus
);
   localparam int OFF_W = $clog2(BLOCK_WIDTH / 8);

   arb_state_e            state_r, next_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [ADDR_WIDTH-1:0] addr_sel_s;
   logic [MAX_ADDR_W-1:0] aligned_s;
   logic                  load_s;
   logic                  launch_rd_s, launch_wr_s;
   logic                  rd_start_r, wr_start_r;
   logic                  cancel_r, cancel_next_s;
   logic                  dfill_s, ifill_s;
   logic                  busy_s;
   logic                  timeout_s;

   assign aligned_s = block_align(MAX_ADDR_W'(addr_sel_s), OFF_W);
   assign busy_s    = (state_r != IDLE);

   // Arbitration, launch decisions and same-cycle fill enables.
   always_comb begin
      next_s        = state_r;
      load_s        = 1'b0;
      addr_sel_s    = '0;
      launch_rd_s   = 1'b0;
      launch_wr_s   = 1'b0;
      dfill_s       = 1'b0;
      ifill_s       = 1'b0;
      cancel_next_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.i_dreq && bus.i_dreq_dirty) begin
               next_s      = WB;
               load_s      = 1'b1;
               addr_sel_s  = bus.i_dwb_addr;
               launch_wr_s = 1'b1;
            end else if (bus.i_dreq) begin
               next_s      = RD_D;
               load_s      = 1'b1;
               addr_sel_s  = bus.i_dreq_addr;
               launch_rd_s = 1'b1;
            end else if (bus.i_ireq && !bus.i_ireq_cancel) begin
               next_s      = RD_I;
               load_s      = 1'b1;
               addr_sel_s  = bus.i_ireq_addr;
               launch_rd_s = 1'b1;
            end else begin
               next_s = IDLE;
            end
         end
         WB: begin
            if (bus.i_axi_done) begin
               next_s      = RD_D;
               load_s      = 1'b1;
               addr_sel_s  = bus.i_dreq_addr;
               launch_rd_s = 1'b1;
            end else begin
               next_s = WB;
            end
         end
         RD_D: begin
            if (bus.i_axi_done) begin
               dfill_s = !i_arst;
               next_s  = IDLE;
            end else begin
               next_s = RD_D;
            end
         end
         RD_I: begin
            // A cancel arriving together with done still suppresses the fill.
            if (bus.i_axi_done) begin
               ifill_s = !i_arst && !cancel_r && !bus.i_ireq_cancel;
               next_s  = IDLE;
            end else begin
               next_s        = RD_I;
               cancel_next_s = cancel_r | bus.i_ireq_cancel;
            end
         end
         default: begin
            next_s = IDLE;
         end
      endcase
   end

   // State, launch address and start pulses.
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         state_r    <= IDLE;
         addr_r     <= '0;
         rd_start_r <= 1'b0;
         wr_start_r <= 1'b0;
         cancel_r   <= 1'b0;
      end else begin
         state_r <= next_s;
         if (load_s) begin
            addr_r <= aligned_s[ADDR_WIDTH-1:0];
         end else begin
            addr_r <= addr_r;
         end
         rd_start_r <= launch_rd_s;
         wr_start_r <= launch_wr_s;
         cancel_r   <= cancel_next_s;
      end
   end

   axi_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (i_clk),
      .rst      (i_arst),
      .clear    (launch_rd_s | launch_wr_s),
      .count_en (busy_s & !bus.i_axi_done),
      .timeout  (timeout_s)
   );

   assign bus.o_axi_addr        = addr_r;
   assign bus.o_axi_read_start  = rd_start_r;
   assign bus.o_axi_write_start = wr_start_r;
   assign bus.o_dfill_we        = dfill_s;
   assign bus.o_ifill_we        = ifill_s;
   assign bus.o_busy            = busy_s;
   assign bus.o_timeout         = timeout_s;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomised scoreboard bench for mem_req_arbiter: the driver predicts each pulse, a monitor checks it.
module tb_mem_req_arbiter;
   localparam int EV_WR = 0;
   localparam int EV_RD = 1;
   localparam int EV_DF = 2;
   localparam int EV_IF = 3;

   typedef struct {
      int          kind;
      int          cyc;
      logic [63:0] addr;
   } ev_t;

   logic clk = 1'b0;
   logic arst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   ev_t  exp_q[$];

   mem_req_arbiter_if #(.ADDR_WIDTH(64)) bus ();

   mem_req_arbiter #(
      .ADDR_WIDTH(64),
      .BLOCK_WIDTH(512),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .i_clk(clk),
      .i_arst(arst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] blk(input logic [63:0] a);
      return a & ~64'h3F;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic push(input int kind, input logic [63:0] addr, input int at);
      ev_t e;
      e.kind = kind; e.addr = addr; e.cyc = at;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic seen(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 64'(kind), 64'(e.kind));
         check("event_cycle", 64'(cyc), 64'(e.cyc));
         check("event_addr", bus.o_axi_addr, e.addr);
      end
   endtask

   // Monitor: every pulse the DUT presents is matched against the next predicted event.
   always @(negedge clk) begin
      if (bus.o_axi_write_start === 1'b1) seen(EV_WR);
      if (bus.o_axi_read_start === 1'b1) seen(EV_RD);
      if (bus.o_dfill_we === 1'b1) seen(EV_DF);
      if (bus.o_ifill_we === 1'b1) seen(EV_IF);
   end

   task automatic idle_inputs();
      bus.i_ireq = 1'b0; bus.i_ireq_cancel = 1'b0; bus.i_dreq = 1'b0;
      bus.i_dreq_dirty = 1'b0; bus.i_axi_done = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      arst = 1'b1;
      tick();
      tick();
      arst = 1'b0;
   endtask

   // One service episode starting in an IDLE cycle; delays k* are cycles after the start pulse.
   task automatic run_txn(input bit ir, input bit dr, input bit dirty,
                          input logic [63:0] ia, input logic [63:0] da, input logic [63:0] wa,
                          input int k1, input int k2, input int k3, input int cancel_off);
      int t;
      int d;
      bus.i_ireq = ir; bus.i_ireq_addr = ia;
      bus.i_dreq = dr; bus.i_dreq_dirty = dirty;
      bus.i_dreq_addr = da; bus.i_dwb_addr = wa;
      if (dr) begin
         t = cyc;
         if (dirty) begin
            push(EV_WR, blk(wa), t + 1);
            tick();
            repeat (k1) tick();
            bus.i_axi_done = 1'b1;
            d = cyc;
            push(EV_RD, blk(da), d + 1);
            tick();
            bus.i_axi_done = 1'b0;
            repeat (k2) tick();
         end else begin
            push(EV_RD, blk(da), t + 1);
            tick();
            repeat (k1) tick();
         end
         bus.i_axi_done = 1'b1;
         d = cyc;
         push(EV_DF, blk(da), d);
         tick();
         bus.i_axi_done = 1'b0;
         bus.i_dreq = 1'b0; bus.i_dreq_dirty = 1'b0;
         check("busy_after_dfill", 64'(bus.o_busy), 64'd0);
      end
      if (ir) begin
         t = cyc;
         push(EV_RD, blk(ia), t + 1);
         tick();
         for (int j = 0; j <= k3; j++) begin
            bus.i_ireq_cancel = (j == cancel_off);
            if (j == k3) begin
               bus.i_axi_done = 1'b1;
               if (cancel_off < 0) push(EV_IF, blk(ia), cyc);
            end
            tick();
         end
         bus.i_axi_done = 1'b0; bus.i_ireq_cancel = 1'b0; bus.i_ireq = 1'b0;
         check("busy_after_ifill", 64'(bus.o_busy), 64'd0);
      end
   endtask

   initial begin
      int t;
      int sel;
      int k3;
      bit dirty;
      idle_inputs();
      bus.i_ireq_addr = '0; bus.i_dreq_addr = '0; bus.i_dwb_addr = '0;
      arst = 1'b1;
      tick();
      check("reset_outputs",
            {bus.o_axi_addr, 57'd0, bus.o_axi_read_start, bus.o_axi_write_start,
             bus.o_ifill_we, bus.o_dfill_we, bus.o_busy, bus.o_timeout, 1'b0}, 128'd0);
      do_reset();

      run_txn(1'b1, 1'b0, 1'b0, 64'h1234, 64'h0, 64'h0, 0, 0, 4, -1);
      run_txn(1'b0, 1'b1, 1'b1, 64'h0, 64'h907F, 64'h8040, 2, 3, 0, -1);
      run_txn(1'b1, 1'b1, 1'b0, 64'h5555, 64'hABCD, 64'h0, 1, 0, 2, -1);
      run_txn(1'b1, 1'b0, 1'b0, 64'h7777, 64'h0, 64'h0, 0, 0, 3, 1);
      run_txn(1'b1, 1'b0, 1'b0, 64'h4444, 64'h0, 64'h0, 0, 0, 2, 2);
      run_txn(1'b1, 1'b0, 1'b0, 64'hC0DE, 64'h0, 64'h0, 0, 0, 0, -1);

      // Cancel present in IDLE blocks the icache launch.
      bus.i_ireq = 1'b1; bus.i_ireq_cancel = 1'b1;
      tick();
      check("cancel_blocks_launch", 64'(bus.o_busy), 64'd0);
      idle_inputs();
      tick();

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 3);
         dirty = 1'($urandom_range(0, 1));
         k3 = $urandom_range(0, 4);
         run_txn(sel == 0 || sel == 3, sel != 0, (sel == 2) || (sel == 3 && dirty),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 4), $urandom_range(0, 4), k3,
                 ($urandom_range(0, 2) == 0) ? $urandom_range(0, k3) : -1);
         repeat ($urandom_range(0, 2)) tick();
      end
      check("no_timeout_normal", 64'(bus.o_timeout), 64'd0);

      // Reset during a write-back, then a stray done.
      t = cyc;
      bus.i_dreq = 1'b1; bus.i_dreq_dirty = 1'b1;
      bus.i_dwb_addr = 64'hDEAD_BEEF_0000_1111; bus.i_dreq_addr = 64'h2222;
      push(EV_WR, 64'hDEAD_BEEF_0000_1100, t + 1);
      tick();
      arst = 1'b1; bus.i_dreq = 1'b0; bus.i_dreq_dirty = 1'b0;
      tick();
      arst = 1'b0; bus.i_axi_done = 1'b1;
      check("reset_mid_wb_addr", bus.o_axi_addr, 64'd0);
      check("reset_mid_wb_busy", 64'(bus.o_busy), 64'd0);
      tick();
      bus.i_axi_done = 1'b0;
      check("stray_done_busy", 64'(bus.o_busy), 64'd0);
      check("stray_done_queue", 64'(exp_q.size()), 64'd0);
      tick();

      // Watchdog: no done for a long time.
      t = cyc;
      bus.i_ireq = 1'b1; bus.i_ireq_addr = 64'h3_0040;
      push(EV_RD, 64'h3_0040, t + 1);
      tick();
      repeat (7) tick();
      check("timeout_before_limit", 64'(bus.o_timeout), 64'd0);
      tick();
      check("timeout_at_limit", 64'(bus.o_timeout), 64'd1);
      bus.i_axi_done = 1'b1;
      push(EV_IF, 64'h3_0040, cyc);
      tick();
      bus.i_axi_done = 1'b0; bus.i_ireq = 1'b0;
      check("timeout_sticky", 64'(bus.o_timeout), 64'd1);
      tick();
      check("timeout_sticky_idle", 64'(bus.o_timeout), 64'd1);
      arst = 1'b1;
      tick();
      arst = 1'b0;
      check("timeout_cleared", 64'(bus.o_timeout), 64'd0);

      run_txn(1'b0, 1'b1, 1'b0, 64'h0, 64'h1_FFFF, 64'h0, 3, 0, 0, -1);
      tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sequences the single shared AXI block-transfer port between instruction-cache refills and data-cache write-back/refill.
- Sits between the caches and the AXI master, in place of the plain combinational start/address mux at top level.
- Registers the launch address, issues one-cycle start pulses, routes completion to the right requester, and lets an in-flight icache refill be cancelled on branch mispredict.
- Includes a watchdog that flags a hung transfer.

Parameters:
- ADDR_WIDTH, 64, byte-address width.
- BLOCK_WIDTH, 512, cache block width in bits; block offset = $clog2(BLOCK_WIDTH/8) = 6.
- TIMEOUT_CYCLES, 1024, cycles to wait for i_axi_done before flagging a timeout.

Ports:
- i_clk  in  1  clock, rising edge.
- i_arst  in  1  reset, synchronous, active-high.
- i_ireq  in  1  icache miss request; held high until serviced.
- i_ireq_addr  in  ADDR_WIDTH  icache miss address.
- i_ireq_cancel  in  1  branch mispredict; drop the current/pending icache refill.
- i_dreq  in  1  dcache miss request; held high until serviced.
- i_dreq_dirty  in  1  victim is dirty; write-back required first.
- i_dreq_addr  in  ADDR_WIDTH  dcache refill address.
- i_dwb_addr  in  ADDR_WIDTH  dirty victim write-back address.
- i_axi_done  in  1  one-cycle transfer-complete pulse.
- o_axi_addr  out  ADDR_WIDTH  block-aligned transfer address.
- o_axi_read_start  out  1  one-cycle read launch pulse.
- o_axi_write_start  out  1  one-cycle write launch pulse.
- o_ifill_we  out  1  icache block write enable.
- o_dfill_we  out  1  dcache block write enable.
- o_busy  out  1  transfer in flight.
- o_timeout  out  1  sticky watchdog flag.

Behaviour:
- Clock and reset: one clock (i_clk); reset i_arst is synchronous and active-high.
- Reset values: state IDLE; every output 0, including o_axi_addr and the sticky o_timeout; cancel flag and watchdog cleared.
- Reset mid-transfer: abandons the transfer immediately; any later i_axi_done seen in IDLE is ignored.
- States: IDLE, WB, RD_D, RD_I.
- IDLE arbitration (fixed priority, dcache over icache):
  - i_dreq & i_dreq_dirty -> WB.
  - i_dreq & ~i_dreq_dirty -> RD_D.
  - else i_ireq & ~i_ireq_cancel -> RD_I.
- Launch timing: the decision is made in cycle t. In cycle t+1, o_axi_*_start = 1 for exactly one cycle. o_axi_addr is loaded at the transition and held stable until done.
  - Write start in WB; read start in RD_D/RD_I.
  - Address source: i_dwb_addr for WB, i_dreq_addr for RD_D, i_ireq_addr for RD_I.
  - Low 6 bits are forced to 0.
- Done handling: i_axi_done is honoured in any cycle of WB/RD_D/RD_I, including the start cycle.
  - WB: done -> RD_D. The refill address is captured from i_dreq_addr on that edge, and read start pulses the next cycle.
  - RD_D: done -> o_dfill_we = 1 combinationally in the same cycle (the data block is valid then); -> IDLE.
  - RD_I: done -> o_ifill_we = 1 in the same cycle, unless the cancel flag is set; -> IDLE.
- Cancel:
  - i_ireq_cancel in RD_I sets the cancel flag. The AXI transfer still completes, but the fill is suppressed.
  - The flag clears on entering IDLE.
  - Cancel outside RD_I has no stored effect.
- Minimum IDLE dwell: IDLE is always held at least one cycle after done. Requesters must drop their request by the cycle after the fill pulse, so no double service occurs.
- o_busy = (state != IDLE).
- Watchdog:
  - Counter clears at launch and increments each busy cycle without done; it saturates.
  - Reaching TIMEOUT_CYCLES sets o_timeout (sticky until reset).
  - The FSM keeps waiting; no abort.
- Simultaneous events:
  - i_dreq and i_ireq in IDLE -> dcache wins; the icache request waits.
  - i_ireq_cancel and done in the same RD_I cycle -> fill suppressed.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, WB, RD_D, RD_I);
  - the localparam BLOCK_OFFSET_W = $clog2(BLOCK_WIDTH/8);
  - the block-align address function.
- Sub-module axi_watchdog, parameterised by TIMEOUT_CYCLES:
  - inputs: clear, count-enable;
  - output: sticky timeout.

Test Plan:
- Reset, then i_ireq = 1 with addr 0x1234 at cycle 0 -> o_axi_read_start = 1 only at cycle 1; o_axi_addr = 0x1200. Done at cycle 5 -> o_ifill_we = 1 at cycle 5; o_busy = 0 at cycle 6.
- i_dreq with dirty = 1, wb addr 0x8040, refill addr 0x907F -> write start with addr 0x8040. Done -> next cycle read start with addr 0x9040. Done -> o_dfill_we = 1 once; o_ifill_we never.
- i_ireq and i_dreq (clean) asserted together -> RD_D serviced first. After fill and the requester dropping, the icache read start fires 2 cycles after the dfill pulse.
- RD_I in flight, i_ireq_cancel pulsed 1 cycle, then done -> no o_ifill_we; returns to IDLE; the next request is served normally.
- Assert i_arst during WB, then deliver a stray i_axi_done -> all outputs 0, state IDLE, no fill pulses.
- TIMEOUT_CYCLES = 8, no done -> o_timeout = 1 after 8 busy cycles and stays 1 after a later done; cleared only by i_arst.
